// File: rtl/op_share_arbiter_pkg.sv
// Shared types and helpers for schedulers that time-share one dataflow operator.
package op_share_arbiter_pkg;

    localparam int unsigned REQ_MAX = 32;
    localparam int unsigned IDW_MAX = 5;

    typedef struct packed {
        logic               valid;
        logic [IDW_MAX-1:0] id;
    } tag_t;

    typedef struct packed {
        logic               found;
        logic [IDW_MAX-1:0] idx;
    } pick_t;

    // Round-robin search starting just after ptr, wrapping at nreq.
    function automatic pick_t rr_pick(input logic [REQ_MAX-1:0] req,
                                      input logic [IDW_MAX-1:0] ptr,
                                      input int unsigned        nreq);
        pick_t       p;
        int unsigned k;
        p = '0;
        for (int unsigned i = 1; i <= REQ_MAX; i++) begin
            k = (32'(ptr) + i) % nreq;
            if (i <= nreq && !p.found && req[k[IDW_MAX-1:0]]) begin
                p.found = 1'b1;
                p.idx   = IDW_MAX'(k);
            end
        end
        return p;
    endfunction

endpackage

// File: rtl/op_share_arbiter_rr_arbiter.sv
// NREQ-wide round-robin arbiter; the pointer moves to the winner on each advancing grant.
module rr_arbiter
    import op_share_arbiter_pkg::*;
#(
    parameter int unsigned NREQ = 4
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               adv,
    input  logic [NREQ-1:0]    req,
    output logic [NREQ-1:0]    gnt_c,
    output logic               gnt_vld_c,
    output logic [IDW_MAX-1:0] gnt_idx_c
);

    logic [IDW_MAX-1:0] ptr_q;
    pick_t              pick_c;

    always_comb begin
        pick_c    = rr_pick(REQ_MAX'(req), ptr_q, NREQ);
        gnt_vld_c = adv & RST & pick_c.found;
        gnt_idx_c = pick_c.idx;
        gnt_c     = '0;
        if (gnt_vld_c) begin
            gnt_c = NREQ'(1) << gnt_idx_c;
        end
    end

    // Reset to the last requester so requester 0 is first in line.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            ptr_q <= IDW_MAX'(NREQ - 1);
        end else if (gnt_vld_c) begin
            ptr_q <= gnt_idx_c;
        end
    end

endmodule

// File: rtl/op_share_arbiter.sv
// Time-shares one fixed-latency operator between NREQ requesters, routing results back by tag.
module op_share_arbiter
    import op_share_arbiter_pkg::*;
#(
    parameter  int unsigned N    = 16,
    parameter  int unsigned NREQ = 4,
    parameter  int unsigned LAT  = 1,
    localparam int unsigned IDW  = $clog2(NREQ),
    localparam int unsigned CW   = $clog2(LAT + 2)
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              EN,
    input  logic [NREQ-1:0]   REQ_R,
    input  logic [NREQ*N-1:0] REQ_D,
    output logic [NREQ-1:0]   REQ_ACK,
    output logic              OP_EN,
    output logic              OP_R,
    output logic [N-1:0]      OP_D,
    input  logic              OP_R_OUT,
    input  logic [N-1:0]      OP_D_OUT,
    output logic [NREQ-1:0]   RES_R,
    output logic [N-1:0]      RES_D,
    output logic [CW-1:0]     INFLIGHT,
    output logic              ERR
);

    logic               gnt_vld_c;
    logic [IDW_MAX-1:0] gnt_idx_c;
    logic [NREQ-1:0]    gnt_c;
    logic [N-1:0]       op_d_nxt_c;
    logic [CW-1:0]      infl_c;
    logic [NREQ-1:0]    res_r_c;

    logic               op_r_q;
    logic [N-1:0]       op_d_q;
    logic               err_q;
    tag_t               tag_q [LAT+1];

    rr_arbiter #(.NREQ(NREQ)) u_rr (
        .CLK       (CLK),
        .RST       (RST),
        .adv       (EN),
        .req       (REQ_R),
        .gnt_c     (gnt_c),
        .gnt_vld_c (gnt_vld_c),
        .gnt_idx_c (gnt_idx_c)
    );

    // Operand mux driven by the one-hot grant.
    always_comb begin
        op_d_nxt_c = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            if (gnt_c[k]) begin
                op_d_nxt_c = REQ_D[k*N +: N];
            end
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            op_r_q <= 1'b0;
            op_d_q <= '0;
            err_q  <= 1'b0;
            for (int unsigned i = 0; i <= LAT; i++) begin
                tag_q[i] <= '0;
            end
        end else if (EN) begin
            op_r_q <= gnt_vld_c;
            if (gnt_vld_c) begin
                op_d_q <= op_d_nxt_c;
            end
            tag_q[0] <= tag_t'{valid: gnt_vld_c, id: gnt_idx_c};
            for (int unsigned i = 1; i <= LAT; i++) begin
                tag_q[i] <= tag_q[i-1];
            end
            // Operator output and tag pipeline must agree on every enabled cycle.
            if (OP_R_OUT != tag_q[LAT].valid) begin
                err_q <= 1'b1;
            end
        end
    end

    always_comb begin
        infl_c = '0;
        for (int unsigned i = 0; i <= LAT; i++) begin
            infl_c = infl_c + CW'(tag_q[i].valid);
        end
    end

    always_comb begin
        res_r_c = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            res_r_c[k] = EN & OP_R_OUT & tag_q[LAT].valid
                       & (tag_q[LAT].id == IDW_MAX'(IDW'(k)));
        end
    end

    assign REQ_ACK  = gnt_c;
    assign OP_EN    = EN;
    assign OP_R     = op_r_q;
    assign OP_D     = op_d_q;
    assign RES_R    = res_r_c;
    assign RES_D    = OP_D_OUT;
    assign INFLIGHT = infl_c;
    assign ERR      = err_q;

endmodule

// File: doc/op_share_arbiter.md
Name: op_share_arbiter

Overview:
- Round-robin scheduler that shares one single-operand dataflow operator (OR/AND/ADD-immediate style: EN, R_IN, D_IN in; R_OUT, D_OUT out; fixed pipeline latency) between NREQ requesters.
- Grants one requester per enabled cycle and registers that requester's operand into the operator.
- Tracks in-flight requester IDs in a tag pipeline and routes each result back on a shared result bus with a one-hot valid.
- Sits between producer operators and one shared arithmetic/logic operator instance in the generated dataflow graph.

Parameters:
- N, 16, operand/result data width.
- NREQ, 4, number of requesters; must be at least 2.
- LAT, 1, operator latency in enabled cycles from operand at R_IN/D_IN to R_OUT/D_OUT; must be at least 1.
- IDW, $clog2(NREQ), requester ID width. Derived; do not override.

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  reset, asynchronous, active-low.
- EN  in  1  global enable; low freezes all state.
- REQ_R  in  NREQ  per-requester operand valid.
- REQ_D  in  NREQ*N  packed operands; requester k uses bits [k*N +: N].
- REQ_ACK  out  NREQ  one-hot grant, combinational, same cycle as the accepted REQ_R.
- OP_EN  out  1  drives operator EN; equals EN.
- OP_R  out  1  registered operand valid to operator R_IN.
- OP_D  out  N  registered operand to operator D_IN.
- OP_R_OUT  in  1  operator R_OUT.
- OP_D_OUT  in  N  operator D_OUT.
- RES_R  out  NREQ  one-hot result valid.
- RES_D  out  N  result data; equals OP_D_OUT.
- INFLIGHT  out  $clog2(LAT+2)  count of valid tags in the pipeline.
- ERR  out  1  sticky protocol error.

Behaviour:
- Reset (RST low, takes effect immediately):
  - OP_R=0, OP_D=0, all tags invalid, INFLIGHT=0, ERR=0.
  - Round-robin pointer = NREQ-1, so requester 0 wins first.
  - REQ_ACK and RES_R read 0 while RST is low.
- Arbitration, evaluated only when EN=1:
  - Search REQ_R starting at pointer+1 with wrap; first set bit k wins.
  - REQ_ACK[k]=1 in that cycle; the requester must present its next operand, or drop REQ_R, on the following cycle.
  - At the edge: OP_D<=REQ_D[k], OP_R<=1, pointer<=k, tag stage 0<={1,k}.
  - If no request: OP_R<=0, tag stage 0<=invalid, pointer unchanged. OP_D holds (don't care).
  - Throughput is one grant per enabled cycle.
- Tag pipeline:
  - LAT+1 stages, shifted on every edge with EN=1; held when EN=0.
  - Stage LAT aligns with OP_R_OUT.
  - End-to-end latency: operand accepted in cycle t; result valid in cycle t+1+LAT, counting enabled cycles only.
- Result routing:
  - RES_R[k] = EN & OP_R_OUT & tag[LAT].valid & (tag[LAT].id==k).
  - Consumers sample RES_D only when the matching RES_R bit is 1.
- EN=0:
  - No REQ_ACK, OP_R/OP_D/tags/pointer held, RES_R=0.
  - OP_EN=0, so the operator holds as well and no result is duplicated or lost.
- INFLIGHT = number of valid tag stages, recomputed from the registered tags.
- ERR is set on any enabled cycle where OP_R_OUT != tag[LAT].valid (result with no tag, or tag with no result). It stays set until reset.
- Simultaneous grant and result delivery in the same cycle is normal and independent.
- A requester that drops REQ_R without an ACK is simply skipped; no state is kept for it.

Decomposition:
- Shared package holds:
  - the tag struct (valid, id[IDW-1:0]);
  - function rr_pick(req, ptr) returning the winner index and a found flag.
- One natural sub-module: rr_arbiter (NREQ-wide round-robin with pointer register, advance-enable input, one-hot grant out). It is reused later by other shared-operator schedulers.

Test Plan:
All scenarios use N=16, NREQ=4, LAT=1, with an OR-immediate operator (I=1) attached.
1. Single request, REQ_R=0100, REQ_D[2]=0x0010, held one cycle:
   - cycle 0: REQ_ACK=0100;
   - cycle 1: OP_R=1, OP_D=0x0010;
   - cycle 2: RES_R=0100, RES_D=0x0011, INFLIGHT returns to 0 in cycle 3.
2. All four requesting continuously from reset, operands 0x0A00+k:
   - grant order 0,1,2,3,0,1;
   - RES_R order 0001,0010,0100,1000 starting cycle 2, data 0x0A01,0x0A01,0x0A03,0x0A03;
   - one result per cycle, ERR=0.
3. Requesters 1 and 3 streaming, EN low for 3 cycles mid-stream:
   - during the freeze: no REQ_ACK, RES_R=0, OP_R/OP_D/INFLIGHT unchanged;
   - after EN returns: results resume in order with no duplicate and no loss.
4. RST pulsed low while INFLIGHT=2:
   - immediately: OP_R=0, RES_R=0, INFLIGHT=0;
   - first grant after release goes to requester 0 even though 2 and 3 are requesting.
5. Forcing OP_R_OUT=1 for one cycle with an empty pipeline -> ERR=1 next cycle, and ERR stays 1 until RST.
6. LAT=3 instance, single request from requester 1:
   - RES_R=0010 exactly 4 enabled cycles after REQ_ACK;
   - INFLIGHT peaks at 1 for a single request and at 4 under continuous requests.
